// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - condition codes, slot states and request bundle for the conditional-execution unit
package cond_unit_pkg;

    // ARM condition field encodings, bits [31:28] of the instruction
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Occupancy of the single-entry output register
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Write requests carried alongside an instruction
    typedef struct packed {
        logic [3:0] flag_write;
        logic       reg_write;
        logic       mem_write;
        logic       pc_src;
    } req_t;

    // Bit positions inside a {N,Z,C,V} flags vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Pass the request bundle through only when enabled, otherwise all zero
    function automatic req_t gate_req(input req_t req, input logic en);
        req_t r;
        r = en ? req : '0;
        return r;
    endfunction

endpackage

// File: rtl/cond_unit_cond_check.sv
// rtl/cond_unit_cond_check.sv - combinational ARM condition evaluation against {N,Z,C,V}
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    // Signed greater-or-equal is shared by GE/LT/GT/LE
    assign w_ge = (w_n == w_v);

    // Decode the condition field into a single pass bit
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = w_ge;
            COND_LT: o_pass = !w_ge;
            COND_GT: o_pass = !w_z && w_ge;
            COND_LE: o_pass = w_z || !w_ge;
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - execute-stage conditional-execution slot with flag interlock and gated write enables
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Cond,
    input  logic [3:0]       FlagWriteReq,
    input  logic             RegWriteReq,
    input  logic             MemWriteReq,
    input  logic             PCSrcReq,
    input  logic [3:0]       Flags,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             CondEx,
    output logic [3:0]       FlagWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             PCSrc,
    output logic [CNT_W-1:0] StallCount
);

    slot_e            r_state;
    slot_e            w_state_nxt;
    req_t             r_req;
    logic             r_cond_ex;
    logic [CNT_W-1:0] r_stall_cnt;

    req_t             w_req_in;
    req_t             w_req_out;
    logic             w_pass;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_pending;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_cnt_sat;

    cond_check u_cond_check (
        .i_cond  (Cond),
        .i_flags (Flags),
        .o_pass  (w_pass)
    );

    assign w_req_in.flag_write = FlagWriteReq;
    assign w_req_in.reg_write  = RegWriteReq;
    assign w_req_in.mem_write  = MemWriteReq;
    assign w_req_in.pc_src     = PCSrcReq;

    assign w_out_valid = (r_state == SLOT_FULL);
    assign w_out_fire  = w_out_valid && OutReady;

    // A held instruction that will write flags makes the Flags input stale for
    // anything conditional; AL does not look at flags and may slip in behind it.
    assign w_pending  = w_out_valid && r_cond_ex && (|r_req.flag_write);
    assign w_hazard   = w_pending && (Cond != COND_AL);
    assign w_in_ready = !w_hazard && (!w_out_valid || OutReady);
    assign w_in_fire  = InValid && w_in_ready;

    assign w_cnt_sat  = (r_stall_cnt == {CNT_W{1'b1}});

    // Slot occupancy register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: a new accept wins over a drain so a same-cycle replace stays full
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_fire) begin
            w_state_nxt = SLOT_FULL;
        end else if (w_out_fire) begin
            w_state_nxt = SLOT_EMPTY;
        end
    end

    // Capture condition result and requests on accept; hold them while stalled
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cond_ex <= 1'b0;
            r_req     <= '0;
        end else if (w_in_fire) begin
            r_cond_ex <= w_pass;
            r_req     <= w_req_in;
        end
    end

    // Count cycles an offered instruction was held back by the flag interlock
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (InValid && w_hazard && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Enables exist only in the fire cycle so each instruction commits exactly once
    assign w_req_out  = gate_req(r_req, r_cond_ex && w_out_fire);

    assign InReady    = w_in_ready;
    assign OutValid   = w_out_valid;
    assign CondEx     = r_cond_ex;
    assign FlagWrite  = w_req_out.flag_write;
    assign RegWrite   = w_req_out.reg_write;
    assign MemWrite   = w_req_out.mem_write;
    assign PCSrc      = w_req_out.pc_src;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit
module tb_cond_unit;

    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, AL = 4'hE;

    typedef struct packed {
        logic       cond_ex;
        logic [3:0] fw;
        logic       rw;
        logic       mw;
        logic       pc;
    } exp_t;

    logic        CLK;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  Cond;
    logic [3:0]  FlagWriteReq;
    logic        RegWriteReq;
    logic        MemWriteReq;
    logic        PCSrcReq;
    logic [3:0]  flags_reg;
    logic        OutValid;
    logic        OutReady;
    logic        CondEx;
    logic [3:0]  FlagWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        PCSrc;
    logic [15:0] StallCount;

    logic        flags_load;
    logic [3:0]  flags_load_val;
    logic [3:0]  alu_flags;

    exp_t        q[$];
    int          applied;
    int          miscompares;

    cond_unit #(.CNT_W(16)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .Cond         (Cond),
        .FlagWriteReq (FlagWriteReq),
        .RegWriteReq  (RegWriteReq),
        .MemWriteReq  (MemWriteReq),
        .PCSrcReq     (PCSrcReq),
        .Flags        (flags_reg),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .CondEx       (CondEx),
        .FlagWrite    (FlagWrite),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .PCSrc        (PCSrc),
        .StallCount   (StallCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Flags register downstream of the unit: loads ALU flags under FlagWrite
    always @(posedge CLK) begin
        if (flags_load) flags_reg <= flags_load_val;
        else flags_reg <= (flags_reg & ~FlagWrite) | (alu_flags & FlagWrite);
    end

    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf & !z;
            4'h9: return !cf | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                if (OutValid && OutReady) begin
                    if (q.size() == 0) begin
                        check("unexpected_fire", 32'(OutValid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("fire_outputs", 32'({CondEx, FlagWrite, RegWrite, MemWrite, PCSrc}), 32'(e));
                    end
                end else begin
                    check("idle_enables_zero", 32'({FlagWrite, RegWrite, MemWrite, PCSrc}), 32'd0);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] v);
        flags_load = 1'b1;
        flags_load_val = v;
        step();
        flags_load = 1'b0;
    endtask

    // Offer one instruction, wait bounded for InReady, record expected response
    task automatic issue(input logic [3:0] c, input logic [3:0] fw, input logic rw, input logic mw,
                         input logic pc, input logic exp_pass, output int waits);
        exp_t e;
        InValid = 1'b1;
        Cond = c;
        FlagWriteReq = fw;
        RegWriteReq = rw;
        MemWriteReq = mw;
        PCSrcReq = pc;
        waits = 0;
        @(negedge CLK);
        while (!InReady && waits < 20) begin
            waits++;
            @(negedge CLK);
        end
        if (!InReady) begin
            check("accept_timeout", 32'(InReady), 32'd1);
        end else begin
            e.cond_ex = exp_pass;
            e.fw = fw & {4{exp_pass}};
            e.rw = rw & exp_pass;
            e.mw = mw & exp_pass;
            e.pc = pc & exp_pass;
            q.push_back(e);
        end
        step();
        InValid = 1'b0;
    endtask

    initial begin
        int w;
        applied = 0;
        miscompares = 0;
        Reset = 1'b1;
        InValid = 1'b0;
        Cond = 4'h0;
        FlagWriteReq = 4'h0;
        RegWriteReq = 1'b0;
        MemWriteReq = 1'b0;
        PCSrcReq = 1'b0;
        OutReady = 1'b1;
        flags_load = 1'b1;
        flags_load_val = 4'h0;
        alu_flags = 4'h0;
        fork
            monitor();
        join_none
        step();
        step();
        Reset = 1'b0;
        flags_load = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        check("rst_condex", 32'(CondEx), 32'd0);
        check("rst_stallcount", 32'(StallCount), 32'd0);
        step();

        // First instruction: EQ with Z=1 writes the register file once
        set_flags(4'b0100);
        issue(EQ, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        check("first_waits", 32'(w), 32'd0);

        // Full condition x flags sweep
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                issue(4'(c), 4'h0, 1'b1, 1'b0, 1'b1, model(4'(c), 4'(f)), w);
            end
        end
        check("sweep_stallcount", 32'(StallCount), 32'd0);

        // CMP then BEQ: BEQ waits one cycle and sees Z=1 from CMP
        set_flags(4'b0000);
        alu_flags = 4'b0100;
        issue(AL, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, w);
        check("cmp_waits", 32'(w), 32'd0);
        issue(EQ, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, w);
        check("beq_waits", 32'(w), 32'd1);
        check("beq_stallcount", 32'(StallCount), 32'd1);

        // AL instruction may follow a pending flag write without stalling
        issue(AL, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, w);
        issue(AL, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        check("al_behind_cmp_waits", 32'(w), 32'd0);
        check("al_stallcount", 32'(StallCount), 32'd1);

        // Failed condition holds no interlock
        issue(NE, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, w);
        issue(EQ, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        check("after_fail_waits", 32'(w), 32'd0);
        check("after_fail_stallcount", 32'(StallCount), 32'd1);
        step();

        // Stalled STR: outputs held, Flags change ignored, MemWrite only on release
        set_flags(4'b0010);
        OutReady = 1'b0;
        issue(CS, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, w);
        set_flags(4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("stall_outvalid", 32'(OutValid), 32'd1);
            check("stall_condex", 32'(CondEx), 32'd1);
            check("stall_inready", 32'(InReady), 32'd0);
            step();
        end
        OutReady = 1'b1;
        step();
        step();

        // Reset while holding a stalled instruction
        OutReady = 1'b0;
        issue(AL, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, w);
        step();
        Reset = 1'b1;
        q.delete();
        step();
        Reset = 1'b0;
        @(negedge CLK);
        check("midrst_outvalid", 32'(OutValid), 32'd0);
        check("midrst_inready", 32'(InReady), 32'd1);
        check("midrst_condex", 32'(CondEx), 32'd0);
        check("midrst_stallcount", 32'(StallCount), 32'd0);
        OutReady = 1'b1;
        step();
        step();
        step();
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
